// File: rtl/s27_bist_pkg.sv
// s27_bist_pkg: shared widths, MISR polynomial and controller states for the s27 BIST
package s27_bist_pkg;
  localparam int LFSR_W = 4;
  localparam int MISR_W = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
  typedef enum logic [2:0] {IDLE, RST_DUT, RUN, CHECK, DONE} state_t;
endpackage

// File: rtl/bist_misr16.sv
// bist_misr16: 16-bit serial-input MISR with synchronous clear and enable
module bist_misr16 import s27_bist_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ {{(MISR_W-1){1'b0}}, din};
endmodule

// File: rtl/s27_bist_controller.sv
// s27_bist_controller: resets s27, drives LFSR patterns, compacts out[0] into a MISR, checks vs golden
module s27_bist_controller import s27_bist_pkg::*; #(
  parameter int unsigned        NUM_PATTERNS = 64,
  parameter int unsigned        RST_CYCLES   = 2,
  parameter logic [LFSR_W-1:0]  LFSR_SEED    = 4'b1001,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pattern_count,
  output logic              dut_rst_n,
  output logic [LFSR_W-1:0] dut_in,
  input  logic              dut_out
);
  localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  state_t state, next;
  logic [3:0] rst_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic launch, stop, last_rst, last_pat;
  assign launch   = (state == IDLE || state == DONE) && start;
  assign busy     = state == RST_DUT || state == RUN || state == CHECK;
  assign stop     = busy && abort;
  assign done     = state == DONE;
  assign dut_rst_n = state != RST_DUT;
  assign dut_in   = state == RUN ? lfsr : '0;
  assign last_rst = rst_cnt == 4'(RST_CYCLES - 1);
  assign last_pat = pattern_count == 16'(NUM_PATTERNS - 1);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = launch ? RST_DUT
         : stop ? IDLE
         : (state == RST_DUT && last_rst) ? RUN
         : (state == RUN && last_pat) ? CHECK
         : (state == CHECK) ? DONE
         : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      rst_cnt       <= '0;
      lfsr          <= SEED;
      pattern_count <= '0;
      pass          <= 1'b0;
    end else begin
      rst_cnt <= (state == RST_DUT && !stop) ? rst_cnt + 4'd1 : '0;
      if (launch) begin
        lfsr          <= SEED;
        pattern_count <= '0;
        pass          <= 1'b0;
      end else if (stop) pass <= 1'b0;
      else if (state == RUN) begin
        lfsr          <= {lfsr[LFSR_W-2:0], lfsr[3] ^ lfsr[2]};
        pattern_count <= &pattern_count ? pattern_count : pattern_count + 16'd1;
      end else if (state == CHECK) pass <= signature == GOLDEN_SIG;
    end
  bist_misr16 u_misr (
    .clk(clk),
    .rst(reset),
    .clr(launch),
    .en (state == RUN && !abort),
    .din(dut_out),
    .sig(signature)
  );
endmodule

// File: doc/s27_bist_controller.md
Name: s27_bist_controller

Overview:
- Built-in self-test sequencer for the s27 benchmark FSM.
- On request it resets the DUT, then drives LFSR pseudo-random patterns onto the DUT's 4-bit input.
- It compacts the DUT's 1-bit output into a 16-bit MISR signature and compares the result against a golden value.
- Sits beside the s27 instance in trojan-detection benches and on-chip test wrappers; the signature mismatch is the trojan indicator.

Parameters:
- NUM_PATTERNS, 64, number of RUN cycles (patterns applied); range 1..65535.
- RST_CYCLES, 2, cycles dut_rst_n is held low before RUN; range 1..15.
- LFSR_SEED, 4'b1001, initial LFSR value; 4'b0000 is replaced by 4'b0001.
- GOLDEN_SIG, 16'h0000, expected MISR signature.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  start request; sampled in IDLE or DONE only.
- abort  input  1  cancel a running test.
- busy  output  1  high in RST_DUT, RUN, CHECK.
- done  output  1  level, high while in DONE.
- pass  output  1  valid when done=1: signature==GOLDEN_SIG.
- signature  output  16  current MISR contents.
- pattern_count  output  16  patterns applied in the current/last run.
- dut_rst_n  output  1  active-low reset to s27; low only in RST_DUT.
- dut_in  output  4  stimulus to s27 in[3:0]; equals LFSR in RUN, 4'b0000 otherwise.
- dut_out  input  1  s27 out[0].

Behaviour:
- Reset (reset=1 at a rising edge) forces:
  - state=IDLE; busy=0, done=0, pass=0.
  - signature=16'h0000, pattern_count=0.
  - dut_rst_n=1, dut_in=0, LFSR=seed.
- Reset mid-run has the same effect; it takes priority over start and abort.
- All outputs are decoded from registers; no combinational path from dut_out to any output.
- States and transitions:
  - IDLE: start=1 -> RST_DUT. On entry to RST_DUT, clear MISR and pattern_count and load LFSR=seed.
  - RST_DUT: dut_rst_n=0 for exactly RST_CYCLES cycles, then -> RUN.
  - RUN, every cycle:
    - dut_in = LFSR.
    - At the clock edge: MISR <= {MISR[14:0],1'b0} ^ (MISR[15] ? 16'h1021 : 16'h0) ^ {15'b0, dut_out}.
    - At the same edge: LFSR <= {LFSR[2:0], LFSR[3]^LFSR[2]}; pattern_count++.
    - After NUM_PATTERNS cycles -> CHECK.
  - CHECK: 1 cycle; pass register <= (MISR==GOLDEN_SIG) -> DONE.
  - DONE: done=1. Signature, pass and pattern_count are held. start=1 -> RST_DUT, and done drops the next cycle.
- Latency: start sampled at cycle T -> done first high at T+1+RST_CYCLES+NUM_PATTERNS+1 (T+68 at defaults).
- abort=1 in RST_DUT, RUN or CHECK:
  - -> IDLE next cycle; done=0, pass=0.
  - signature and pattern_count hold their partial values.
- abort in IDLE or DONE is ignored.
- start while busy is ignored. Simultaneous start and abort while busy: abort wins.
- Simultaneous start and abort in DONE: start wins (abort ignored).
- LFSR is maximal-length, period 15; the sequence wraps naturally when NUM_PATTERNS>15.
- pattern_count saturates at its width (NUM_PATTERNS max bounds it).

Decomposition:
- Package s27_bist_pkg holds:
  - state enum (IDLE, RST_DUT, RUN, CHECK, DONE).
  - MISR_POLY=16'h1021.
  - LFSR/MISR widths.
- One sub-module, bist_misr16: the 16-bit MISR with clear, enable and serial input.
- The LFSR and the FSM stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles -> busy=0, done=0, pass=0, signature=16'h0000, dut_rst_n=1, dut_in=4'h0.
- Stimulus order: start pulse at T, defaults -> dut_rst_n=0 at T+1..T+2; dut_in = 1001, 0011, 0110, 1101, 1010, 0101 on the first six RUN cycles; pattern wraps to 1001 on RUN cycle 16; done=1 at T+68.
- Compaction:
  - dut_out tied 0, GOLDEN_SIG=0 -> signature=16'h0000, pass=1.
  - dut_out tied 1, NUM_PATTERNS=2 -> signature=16'h0003, pass=0.
- Connect real s27 with GOLDEN_SIG taken from a clean run -> pass=1; inject a stuck-at-1 on s27 out -> pass=0.
- abort asserted on RUN cycle 10 -> IDLE next cycle, busy=0, done=0, pattern_count=10; start ignored while busy; a new start clears pattern_count to 0.
- reset asserted during RUN -> next cycle all outputs at reset values; a subsequent start runs a full test identical to a fresh one (same signature).
